// File: rtl/pe_dot_pipeline.sv
// -----------------------------------------------------------------------------
// pe_dot_pipeline
//
// Pipelined dot-product chain: o_psum = i_psum + sum_k x_k * w_k over D lanes,
// one multiply-accumulate stage per lane, one vector accepted per cycle.
// Weights sit in per-stage registers and are reloaded serially through a small
// IDLE / DRAIN / LOAD / READY state machine. A reload request waits for all
// in-flight vectors to leave the chain, so they finish with the old weights.
//
// Optional build macro:
//   PE_DOT_SATURATE_EN  - when defined, every stage sum is formed one bit wider
//                         and clamped to the signed BW2 range. When undefined,
//                         stage sums simply wrap modulo 2^BW2.
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_valid     input vector valid
//   i_x         D packed signed activations, lane k = i_x[k*XW +: XW]
//   i_psum      signed input partial sum (sign-extended to BW2)
//   i_w_start   request a weight reload
//   i_w_valid   weight word valid while loading
//   i_w         signed weight word; first word loaded ends up in stage 0
//   o_valid     result valid (D cycles after an accepted vector)
//   o_psum      signed result, holds its value while o_valid is low
//   o_w_ready   weights loaded, vectors are being accepted
//   o_err       one-cycle pulse after an i_valid that was dropped
// -----------------------------------------------------------------------------
module pe_dot_pipeline #(
   parameter int XW  = 8,
   parameter int WW  = 8,
   parameter int BW1 = 16,
   parameter int BW2 = 20,
   parameter int D   = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid,
   input  logic [D*XW-1:0]       i_x,
   input  logic signed [BW1-1:0] i_psum,
   input  logic                  i_w_start,
   input  logic                  i_w_valid,
   input  logic signed [WW-1:0]  i_w,
   output logic                  o_valid,
   output logic signed [BW2-1:0] o_psum,
   output logic                  o_w_ready,
   output logic                  o_err
);

   localparam int CW = (D > 1) ? $clog2(D) : 1;
   localparam int PW = XW + WW;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_LOAD,
      ST_READY
   } state_t;

   state_t                state_reg, state_next;
   logic [CW-1:0]         cnt_reg, cnt_next;
   logic                  w_shift;
   logic signed [WW-1:0]  w_reg [0:D-1];
   logic [D-1:0]          vld_vec;
   logic                  pipe_busy;
   logic                  accept;
   logic                  w_ready_reg;
   logic                  err_reg;

   // Stage adder. The saturating form extends both operands by one bit so
   // that an overflow shows up as a disagreement between the top two bits.
   function automatic logic signed [BW2-1:0] stage_add(
      input logic signed [BW2-1:0] a,
      input logic signed [BW2-1:0] b
   );
`ifdef PE_DOT_SATURATE_EN
      logic [BW2:0] wide;
      wide = {a[BW2-1], a} + {b[BW2-1], b};
      if (wide[BW2] != wide[BW2-1]) begin
         if (wide[BW2])
            return {1'b1, {(BW2-1){1'b0}}};
         else
            return {1'b0, {(BW2-1){1'b1}}};
      end
      return wide[BW2-1:0];
`else
      return a + b;
`endif
   endfunction

   assign pipe_busy = |vld_vec;

   // A vector is taken only in READY and never alongside a reload request.
   assign accept = (state_reg == ST_READY) && i_valid && !i_w_start;

   // ---------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      w_shift    = 1'b0;
      case (state_reg)
         ST_IDLE, ST_READY: begin
            if (i_w_start) begin
               state_next = pipe_busy ? ST_DRAIN : ST_LOAD;
               cnt_next   = '0;
            end
         end
         ST_DRAIN: begin
            // Move to LOAD once a whole cycle has seen the chain empty.
            if (!pipe_busy) begin
               state_next = ST_LOAD;
               cnt_next   = '0;
            end
         end
         ST_LOAD: begin
            // A fresh request restarts the word count; the next D words
            // overwrite whatever was shifted in so far.
            if (i_w_start) begin
               cnt_next = '0;
            end else if (i_w_valid) begin
               w_shift = 1'b1;
               if (cnt_reg == CW'(D - 1)) begin
                  state_next = ST_READY;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         w_ready_reg <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         w_ready_reg <= (state_next == ST_READY);
         err_reg     <= i_valid && !accept;
      end
   end

   // ---------------------------------------------------------------------
   // Weight shift register: new words enter at the top stage and move down,
   // so after D words the first one sits in stage 0.
   // ---------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < D; k++)
            w_reg[k] <= '0;
      end else if (w_shift) begin
         for (int k = 0; k < D - 1; k++)
            w_reg[k] <= w_reg[k + 1];
         w_reg[D - 1] <= i_w;
      end
   end

   // ---------------------------------------------------------------------
   // MAC stages
   // ---------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < D; gi++) begin : g_stage
         logic signed [XW-1:0]  x_lane;
         logic signed [PW-1:0]  prod;
         logic signed [BW2-1:0] prod_ext;
         logic signed [BW2-1:0] sum_in;
         logic                  vld_in;
         logic signed [BW2-1:0] sum_reg;
         logic                  vld_reg;

         if (gi == 0) begin : g_head
            assign x_lane = i_x[XW-1:0];
            assign sum_in = BW2'(i_psum);
            assign vld_in = accept;
         end else begin : g_tail
            // Lane gi is delayed gi cycles so it reaches this stage together
            // with the partial sum of the same vector.
            logic signed [XW-1:0] skew_reg [0:gi-1];

            always_ff @(posedge i_clk or negedge i_rst_n) begin
               if (!i_rst_n) begin
                  for (int j = 0; j < gi; j++)
                     skew_reg[j] <= '0;
               end else begin
                  skew_reg[0] <= i_x[gi*XW +: XW];
                  for (int j = 1; j < gi; j++)
                     skew_reg[j] <= skew_reg[j - 1];
               end
            end

            assign x_lane = skew_reg[gi - 1];
            assign sum_in = g_stage[gi - 1].sum_reg;
            assign vld_in = g_stage[gi - 1].vld_reg;
         end

         assign prod     = PW'(x_lane) * PW'(w_reg[gi]);
         assign prod_ext = BW2'(prod);

         // Bubbles advance the valid bit but leave the stored sum alone.
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               sum_reg <= '0;
               vld_reg <= 1'b0;
            end else begin
               vld_reg <= vld_in;
               if (vld_in)
                  sum_reg <= stage_add(sum_in, prod_ext);
            end
         end

         assign vld_vec[gi] = vld_reg;
      end
   endgenerate

   assign o_valid   = g_stage[D - 1].vld_reg;
   assign o_psum    = g_stage[D - 1].sum_reg;
   assign o_w_ready = w_ready_reg;
   assign o_err     = err_reg;

endmodule
